// File: rtl/bus_settle_pkg.sv
// Shared types and constants for the bus settle receiver and its synchroniser.
package bus_settle_pkg;

   typedef enum logic [0:0] {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } state_t;

   localparam int unsigned GLITCH_W = 8;
   localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((1 << width) < value) begin
         width++;
      end
      return (width == 0) ? 1 : width;
   endfunction

endpackage

// File: rtl/bus_sync_chain.sv
// WIDTH x STAGES flop synchroniser; every stage resets asynchronously to RESET_VALUE.
module bus_sync_chain #(
   parameter int unsigned         WIDTH       = 8,
   parameter int unsigned         STAGES      = 2,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= RESET_VALUE;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/bus_settle_receiver.sv
// Synchronises and debounces an asynchronous bus; commits a value once it has been stable.
// Optional glitch counter is built only when BUS_SETTLE_GLITCH_COUNT_EN is defined.
module bus_settle_receiver
   import bus_settle_pkg::*;
#(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      SYNC_STAGES   = 2,
   parameter int unsigned      SETTLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic                CLK,
   input  logic                nRESET,
   input  logic [WIDTH-1:0]    I,
   output logic [WIDTH-1:0]    O,
   output logic                VALID,
   output logic                CHANGE,
   output logic [WIDTH-1:0]    RISE,
   output logic [WIDTH-1:0]    FALL,
   output logic [GLITCH_W-1:0] GLITCHES
);

   localparam int unsigned    CNT_W    = clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [WIDTH-1:0] s;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             change_q, change_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             commit;
   logic [WIDTH-1:0] commit_val;

   bus_sync_chain #(
      .WIDTH       (WIDTH),
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (RESET_VALUE)
   ) u_sync (
      .clk_i  (CLK),
      .rst_ni (nRESET),
      .d_i    (I),
      .q_o    (s)
   );

   always_comb begin
      state_d    = state_q;
      o_d        = o_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      change_d   = 1'b0;
      rise_d     = '0;
      fall_d     = '0;
      commit     = 1'b0;
      commit_val = s;

      unique case (state_q)
         STABLE: begin
            if (s != o_q) begin
               if (SETTLE_CYCLES == 1) begin
                  commit     = 1'b1;
                  commit_val = s;
               end else begin
                  cand_d  = s;
                  cnt_d   = CNT_W'(1);
                  state_d = SETTLING;
               end
            end
         end
         SETTLING: begin
            // Bounce back to the committed value is a rejected glitch.
            if (s == o_q) begin
               state_d = STABLE;
            end else if (s != cand_q) begin
               cand_d = s;
               cnt_d  = CNT_W'(1);
            end else if (cnt_q == CNT_LAST) begin
               commit     = 1'b1;
               commit_val = cand_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = STABLE;
      endcase

      if (commit) begin
         o_d      = commit_val;
         change_d = 1'b1;
         rise_d   = commit_val & ~o_q;
         fall_d   = ~commit_val & o_q;
         state_d  = STABLE;
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q  <= STABLE;
         o_q      <= RESET_VALUE;
         cand_q   <= RESET_VALUE;
         cnt_q    <= '0;
         change_q <= 1'b0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         state_q  <= state_d;
         o_q      <= o_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         change_q <= change_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

`ifdef BUS_SETTLE_GLITCH_COUNT_EN
   logic                glitch_evt;
   logic [GLITCH_W-1:0] glitch_q;

   assign glitch_evt = (state_q == SETTLING) && (s == o_q);

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         glitch_q <= '0;
      end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
         glitch_q <= glitch_q + 1'b1;
      end
   end

   assign GLITCHES = glitch_q;
`else
   assign GLITCHES = '0;
`endif

   assign O      = o_q;
   assign VALID  = (state_q == STABLE);
   assign CHANGE = change_q;
   assign RISE   = rise_q;
   assign FALL   = fall_q;

endmodule
